vote_peer: RTL

VOTE_PEER -- requirements
Module: vote_peer

---
 rtl/vote_peer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/vote_peer.sv
// Peer side of the four-wire vote handshake: receives words from the voting station,
// returns reply words, counts completed rounds and aborts on a stalled handshake.
`timescale 1ns/1ps
module vote_peer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       cts,
  input  logic       ctr,
  input  logic [3:0] v_in,
  input  logic [3:0] reply_data,
  output logic       rtr,
  output logic       rts,
  output logic [3:0] v_out,
  output logic [3:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       done,
  output logic       timeout_err,
  output logic [3:0] rounds
);

  localparam int unsigned CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]  EndCode = 4'b0110;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StCheck,
    StRtsLow,
    StData,
    StWaitAck,
    StRelease,
    StEndWait,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              timed;
  logic              rtr_q, rtr_d;
  logic              rts_q, rts_d;
  logic [3:0]        v_out_q, v_out_d;
  logic [3:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              parity_q, parity_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic [3:0]        rounds_q, rounds_d;

  always_comb begin
    state_d    = state_q;
    v_out_d    = v_out_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    parity_d   = parity_q;
    done_d     = 1'b0;
    terr_d     = terr_q;
    rounds_d   = rounds_q;
    timed      = 1'b0;
    cnt_inc    = cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StReq;
          rounds_d = 4'd0;
          terr_d   = 1'b0;
        end
      end
      StReq: begin
        timed = 1'b1;
        if (cts) begin
          rx_data_d  = v_in;
          rx_valid_d = 1'b1;
          parity_d   = v_in[3] ^ (^v_in[2:0]);
          state_d    = StCheck;
        end
      end
      StCheck: begin
        state_d = (rx_data_q == EndCode) ? StEndWait : StRtsLow;
      end
      StRtsLow: begin
        timed = 1'b1;
        if (ctr) begin
          v_out_d = reply_data;
          state_d = StData;
        end
      end
      StData: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        timed = 1'b1;
        if (!ctr) begin
          rounds_d = (rounds_q == 4'd15) ? rounds_q : rounds_q + 4'd1;
          state_d  = StRelease;
        end
      end
      StRelease: begin
        timed = 1'b1;
        if (!cts) state_d = StReq;
      end
      StEndWait: begin
        timed = 1'b1;
        if (!cts) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StError: begin
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A handshake event seen in the same cycle as the limit wins over the abort.
    if (timed && (state_d == state_q) && (cnt_inc == CntW'(TIMEOUT_CYCLES))) begin
      state_d = StError;
      terr_d  = 1'b1;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (timed) begin
      cnt_d = cnt_inc;
    end else begin
      cnt_d = cnt_q;
    end

    // Strobes are registered from the next state; rts rises only on leaving DATA, so the
    // reply word loaded on DATA entry has a full cycle to settle before the rising edge.
    rtr_d = state_d inside {StReq, StCheck, StRtsLow, StData, StWaitAck};
    rts_d = !(state_d inside {StRtsLow, StData});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rtr_q      <= 1'b0;
      rts_q      <= 1'b1;
      v_out_q    <= 4'd0;
      rx_data_q  <= 4'd0;
      rx_valid_q <= 1'b0;
      parity_q   <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      rounds_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rtr_q      <= rtr_d;
      rts_q      <= rts_d;
      v_out_q    <= v_out_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      parity_q   <= parity_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
      rounds_q   <= rounds_d;
    end
  end

  assign rtr         = rtr_q;
  assign rts         = rts_q;
  assign v_out       = v_out_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = parity_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign rounds      = rounds_q;

endmodule
